// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a FIFO and serialises each one LSB first as an 8N1/8N2 UART frame on tx.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    input  logic [7:0] fifo_rd_data,
    output logic       tx,
    output logic       busy,
    output logic       byte_done
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, START, DATA, STOP} state_t;
    state_t state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic tx_q, tx_d, rd_en_q, rd_en_d, busy_q, busy_d, done_q, done_d;
    logic go, baud_end, timed;
    assign go = enable && !fifo_empty;
    assign baud_end = baud_q == BAUD_LAST;
    assign timed = state_q inside {START, DATA, STOP};
    always_comb begin
        state_d = state_q;
        bit_d = bit_q;
        shift_d = shift_q;
        baud_d = (timed && !baud_end) ? baud_q + BW'(1) : '0;
        case (state_q)
            IDLE:    state_d = go ? FETCH : IDLE;
            FETCH:   state_d = CAPTURE;
            CAPTURE: begin
                state_d = START;
                shift_d = fifo_rd_data;
                bit_d = '0;
            end
            START:   state_d = baud_end ? DATA : START;
            DATA:    if (baud_end) begin
                shift_d = shift_q >> 1;
                bit_d = bit_q + 3'd1;
                state_d = (bit_q == 3'd7) ? STOP : DATA;
            end
            STOP:    if (baud_end) begin
                bit_d = (bit_q == STOP_LAST) ? 3'd0 : bit_q + 3'd1;
                state_d = (bit_q != STOP_LAST) ? STOP : go ? FETCH : IDLE;
            end
            default: state_d = IDLE;
        endcase
        // outputs are decoded from the next state so the registered pins line up with state_q
        tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
        rd_en_d = state_d == FETCH;
        busy_d = state_d != IDLE;
        done_d = state_d == STOP && baud_d == BAUD_LAST && bit_d == STOP_LAST;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            baud_q <= '0;
            bit_q <= '0;
            shift_q <= '0;
            tx_q <= 1'b1;
            rd_en_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q <= baud_d;
            bit_q <= bit_d;
            shift_q <= shift_d;
            tx_q <= tx_d;
            rd_en_q <= rd_en_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end
    assign tx = tx_q;
    assign fifo_rd_en = rd_en_q;
    assign busy = busy_q;
    assign byte_done = done_q;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: drives two transmitters (1 and 2 stop bits) from queue-backed FIFOs
// and compares every cycle against a frame-position model, plus directed frame captures.
module tb_fifo_uart_tx;
    localparam int CPB = 4;
    typedef struct { logic [7:0] data; logic [9:0] frame; } vec_t;
    logic clk = 1'b0, rst = 1'b0, enable = 1'b0;
    logic fifo_empty [2] = '{1'b1, 1'b1};
    logic [7:0] rd_data [2] = '{8'h00, 8'h00};
    logic tx_w [2], rd_en_w [2], busy_w [2], done_w [2];
    logic [7:0] fq [2][$];
    int checks = 0, errors = 0;
    int rd_cnt [2] = '{0, 0};
    bit act [2] = '{1'b0, 1'b0};
    int p [2] = '{0, 0};
    logic [7:0] byt [2] = '{8'h00, 8'h00};

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty[0]),
        .fifo_rd_en(rd_en_w[0]), .fifo_rd_data(rd_data[0]), .tx(tx_w[0]),
        .busy(busy_w[0]), .byte_done(done_w[0]));
    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty[1]),
        .fifo_rd_en(rd_en_w[1]), .fifo_rd_data(rd_data[1]), .tx(tx_w[1]),
        .busy(busy_w[1]), .byte_done(done_w[1]));

    // frame length from the rd_en cycle: fetch + capture + start + 8 data + stop bits
    function automatic int flen(int i);
        return 2 + CPB * (10 + i);
    endfunction

    function automatic logic [3:0] expv(int i);
        int idx;
        logic t;
        if (!act[i]) return 4'b1000;
        t = 1'b1;
        if (p[i] >= 2) begin
            idx = (p[i] - 2) / CPB;
            t = (idx == 0) ? 1'b0 : (idx <= 8) ? byt[i][idx-1] : 1'b1;
        end
        return {t, p[i] == 0, 1'b1, p[i] == flen(i) - 1};
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) act[i] = 1'b0;
            else if (!act[i] || p[i] == flen(i) - 1) begin
                act[i] = enable && !fifo_empty[i];
                p[i] = 0;
                if (act[i]) byt[i] = fq[i][0];
            end else p[i]++;
            if (rd_en_w[i]) begin
                rd_cnt[i]++;
                if (fq[i].size() > 0) rd_data[i] <= fq[i].pop_front();
            end
            fifo_empty[i] <= fq[i].size() == 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [3:0] e, g;
            e = expv(i);
            g = {tx_w[i], rd_en_w[i], busy_w[i], done_w[i]};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL cycle dut%0d t=%0t got %b exp %b (tx,rd_en,busy,done)", i, $time, g, e);
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", n, got, exp);
        end
    endtask

    task automatic push(input int d, input logic [7:0] b);
        fq[d].push_back(b);
    endtask

    task automatic wait_start(input int d, output int gap);
        gap = 0;
        while (tx_w[d] !== 1'b0 && gap < 400) begin
            @(negedge clk);
            gap++;
        end
        chk("tx_start", 32'(tx_w[d]), 0);
    endtask

    task automatic capture(input int d, output logic [9:0] f, output int gap);
        wait_start(d, gap);
        f = '0;
        for (int k = 0; k < 10 * CPB; k++) begin
            if (k % CPB == CPB / 2) f[k/CPB] = tx_w[d];
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while (busy_w[d] !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("idle", 32'(busy_w[d]), 0);
    endtask

    initial begin
        vec_t tbl [5];
        logic [9:0] f;
        int gap, c0, n, d;
        tbl = '{'{8'hA5, 10'h34A}, '{8'h01, 10'h202}, '{8'h80, 10'h300},
                '{8'hFF, 10'h3FE}, '{8'h00, 10'h200}};
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++)
            chk("reset_out", {28'd0, tx_w[i], rd_en_w[i], busy_w[i], done_w[i]}, 4'b1000);
        rst = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            c0 = rd_cnt[0];
            push(0, tbl[i].data);
            capture(0, f, gap);
            chk("frame", f, tbl[i].frame);
            wait_idle(0);
            chk("rd_pulses", rd_cnt[0] - c0, 1);
        end
        c0 = rd_cnt[0];
        push(0, 8'h01); push(0, 8'h80); push(0, 8'hFF);
        capture(0, f, gap); chk("b2b_frame0", f, 10'h202);
        capture(0, f, gap); chk("b2b_frame1", f, 10'h300); chk("b2b_gap1", gap, 2);
        capture(0, f, gap); chk("b2b_frame2", f, 10'h3FE); chk("b2b_gap2", gap, 2);
        wait_idle(0);
        chk("b2b_pulses", rd_cnt[0] - c0, 3);
        c0 = rd_cnt[0];
        repeat (200) @(negedge clk);
        chk("empty_no_rd", rd_cnt[0] - c0, 0);
        chk("empty_busy", 32'(busy_w[0]), 0);
        chk("empty_tx", 32'(tx_w[0]), 1);
        c0 = rd_cnt[0];
        push(0, 8'h96); push(0, 8'h69);
        wait_start(0, gap);
        repeat (18) @(negedge clk);
        enable = 1'b0;
        wait_idle(0);
        repeat (20) @(negedge clk);
        chk("disable_pulses", rd_cnt[0] - c0, 1);
        chk("disable_left", fq[0].size(), 1);
        enable = 1'b1;
        capture(0, f, gap);
        chk("reenable_frame", f, 10'h2D2);
        wait_idle(0);
        chk("reenable_pulses", rd_cnt[0] - c0, 2);
        push(1, 8'h3C);
        capture(1, f, gap);
        chk("sb2_frame", f, 10'h278);
        repeat (3) @(negedge clk);
        chk("sb2_done", 32'(done_w[1]), 1);
        chk("sb2_tx", 32'(tx_w[1]), 1);
        @(negedge clk);
        chk("sb2_end", 32'(busy_w[1]), 0);
        push(1, 8'hC3);
        wait_start(1, gap);
        repeat (4 + 5 * CPB + 1) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tx", 32'(tx_w[1]), 1);
        chk("rst_busy", 32'(busy_w[1]), 0);
        rst = 1'b1;
        c0 = rd_cnt[1];
        push(1, 8'h5A);
        capture(1, f, gap);
        chk("post_rst_frame", f, 10'h2B4);
        wait_idle(1);
        chk("post_rst_pulses", rd_cnt[1] - c0, 1);
        repeat (800) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                d = int'($urandom_range(0, 1));
                if (fq[d].size() < 16) push(d, 8'($urandom));
            end
            if ($urandom_range(0, 39) == 0) enable = !enable;
        end
        enable = 1'b1;
        n = 0;
        while ((fq[0].size() != 0 || fq[1].size() != 0 || busy_w[0] !== 1'b0 || busy_w[1] !== 1'b0) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", {fq[0].size() != 0, fq[1].size() != 0, busy_w[0], busy_w[1]}, 0);
        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
